lcd_bin2dec: RTL
================

Name: lcd_bin2dec

Overview:
Sequential binary-to-decimal converter that drives the 8 character inputs (iChar7..iChar0, 5 bits each) of the lcd24x3 segment driver. It converts an unsigned binary count to 8 BCD digits using serial double-dabble, one bit per clock. Optional leading-zero blanking and overflow indication are applied before the outputs update. It sits between counter or measurement logic and lcd24x3, in the same clock domain.

Parameters:
WIDTH, 27, width of the binary input; 27 bits covers 0..99_999_999.
DIGITS, 8, number of decimal output digits; fixed to match the lcd24x3 character count.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  asynchronous, active-high reset.
iValue  input  WIDTH  unsigned binary value; sampled only on an accepted iStart.
iStart  input  1  conversion request; level-sampled on each clk edge.
iBlank  input  1  leading-zero suppression enable; sampled together with iValue.
oChar7..oChar0  output  5 each  character codes; oChar0 is the least significant digit; connect 1:1 to lcd24x3 iChar7..iChar0.
oBusy  output  1  high while a conversion is in progress.
oDone  output  1  one-cycle pulse in the cycle the oChar outputs update.
oOverflow  output  1  high when the last accepted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (asynchronous): state goes to IDLE. All oChar = 5'h00. oBusy = 0, oDone = 0, oOverflow = 0. The internal shift and BCD registers clear.
- Character codes: 5'h00..5'h09 are digits 0..9. CH_BLANK = 5'h1F. CH_MINUS = 5'h10.
- State machine:
  - IDLE: if iStart = 1, latch iValue and iBlank, clear the BCD register, load the bit counter with WIDTH, and go to SHIFT. oBusy becomes 1 from the next cycle.
  - SHIFT: each cycle, every BCD nibble >= 5 gets +3; then the combined {BCD, bin} register shifts left by one and the bit counter decrements. After exactly WIDTH SHIFT cycles, go to FORMAT.
  - FORMAT: one cycle. Apply overflow handling and blanking, computed combinationally from the BCD register, and register the result into all oChar outputs in this cycle. Pulse oDone = 1 for one cycle, drop oBusy to 0, and return to IDLE.
- Latency: iStart sampled at edge N gives oDone high and new oChar values in cycle N+WIDTH+2, which is 29 cycles by default. Back-to-back throughput is one conversion per WIDTH+2 cycles; iStart held high in IDLE starts the next conversion immediately.
- iStart while oBusy = 1 is ignored. There is no queuing and the latched value is unaffected.
- Overflow: the latched value is compared against 10^DIGITS-1 (99_999_999) at latch time and the flag is carried to FORMAT.
  - On overflow: all oChar = CH_MINUS and oOverflow = 1.
  - Otherwise: oOverflow = 0.
  - Values 99_999_999 < v <= 2^WIDTH-1 overflow.
- Blanking (iBlank = 1 and no overflow): digits above the most significant non-zero digit become CH_BLANK. oChar0 is never blanked, so value 0 shows a single "0". With iBlank = 0, all digits are shown.
- oChar, oOverflow and oDone change only in FORMAT or on reset, so the display never shows intermediate shift values.
- Reset during SHIFT or FORMAT aborts the conversion. Outputs take their reset values, and no oDone pulse is issued.
- Arithmetic: BCD register width is 4*DIGITS. The bit counter is $clog2(WIDTH+1) bits. The overflow constant is computed as a 64-bit localparam.

Decomposition:
- Package lcd_pkg holds CH_BLANK, CH_MINUS, LCD_DIGITS = 8 and CHAR_W = 5; it is shared with lcd24x3 users.
- One sub-module, bcd_add3: combinational 4-bit "if >= 5 add 3" nibble correction, instantiated DIGITS times in a generate loop.
- The FSM, shift register and format logic live in lcd_bin2dec.

Test Plan:
1. iValue = 12_345_678, iBlank = 0, iStart pulse -> after 29 cycles oDone = 1, oChar7..0 = 1,2,3,4,5,6,7,8, oOverflow = 0, oBusy high for 28 cycles.
2. iValue = 0, iBlank = 1 -> oChar0 = 5'h00, oChar7..1 = 5'h1F. iValue = 4_050, iBlank = 1 -> oChar3..0 = 4,0,5,0, oChar7..4 = 5'h1F.
3. iValue = 99_999_999 -> all oChar = 5'h09, oOverflow = 0. iValue = 100_000_000 -> all oChar = 5'h10, oOverflow = 1. iValue = 2^27-1 -> all oChar = 5'h10, oOverflow = 1.
4. Start 123, then iStart with 456 ten cycles later (busy) -> only 123 is displayed and exactly one oDone; iStart held high -> oDone every 29 cycles.
5. Assert rst for 1 cycle at SHIFT cycle 12 -> oBusy = 0 and all oChar = 5'h00 immediately, no oDone; a new start with 7 then yields oChar0 = 7.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared character codes and helpers for lcd24x3 users
// Contents:
//   LCD_DIGITS, CHAR_W     : character count and width of the lcd24x3 inputs
//   CH_BLANK, CH_MINUS     : non-digit character codes (digits are 5'h00..5'h09)
//   b2d_state_t            : converter FSM states
//   pow10()                : 64-bit power of ten for elaboration-time limits
package lcd_pkg;

  localparam int LCD_DIGITS = 8;
  localparam int CHAR_W     = 5;

  localparam logic [CHAR_W-1:0] CH_BLANK = 5'h1F;
  localparam logic [CHAR_W-1:0] CH_MINUS = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } b2d_state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_bin2dec_if.sv
// rtl/lcd_bin2dec_if.sv - request/result bundle between a value source and lcd_bin2dec
// Signals:
//   iValue, iStart, iBlank : conversion request (driven by the master)
//   oChar7..oChar0         : character codes, oChar0 least significant digit
//   oBusy, oDone, oOverflow: conversion status (driven by the slave)
// Modports: master = requester side, slave = converter side.
interface lcd_bin2dec_if #(
  parameter int WIDTH = 27
);
  import lcd_pkg::*;

  logic [WIDTH-1:0]  iValue;
  logic              iStart;
  logic              iBlank;
  logic [CHAR_W-1:0] oChar7;
  logic [CHAR_W-1:0] oChar6;
  logic [CHAR_W-1:0] oChar5;
  logic [CHAR_W-1:0] oChar4;
  logic [CHAR_W-1:0] oChar3;
  logic [CHAR_W-1:0] oChar2;
  logic [CHAR_W-1:0] oChar1;
  logic [CHAR_W-1:0] oChar0;
  logic              oBusy;
  logic              oDone;
  logic              oOverflow;

  modport master (
    output iValue, iStart, iBlank,
    input  oChar7, oChar6, oChar5, oChar4, oChar3, oChar2, oChar1, oChar0,
    input  oBusy, oDone, oOverflow
  );

  modport slave (
    input  iValue, iStart, iBlank,
    output oChar7, oChar6, oChar5, oChar4, oChar3, oChar2, oChar1, oChar0,
    output oBusy, oDone, oOverflow
  );

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: add 3 when the nibble is 5 or more
// Ports:
//   din  : BCD nibble before the shift
//   dout : corrected nibble, so the following left shift carries correctly into the next digit
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/lcd_bin2dec.sv
// rtl/lcd_bin2dec.sv - serial double-dabble binary to 8-digit character converter for lcd24x3
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : lcd_bin2dec_if slave (iValue/iStart/iBlank in; oChar7..0, oBusy, oDone, oOverflow out)
// One binary bit is consumed per SHIFT cycle; a single FORMAT cycle then applies
// overflow and leading-zero blanking and updates every character at once.
module lcd_bin2dec
  import lcd_pkg::*;
#(
  parameter int WIDTH  = 27,
  parameter int DIGITS = LCD_DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  lcd_bin2dec_if.slave bus
);

  localparam int          CNT_W   = $clog2(WIDTH + 1);
  localparam int          BCD_W   = 4 * DIGITS;
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  b2d_state_t state_q, state_d;

  logic [WIDTH-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              blank_q;
  logic              ovf_q;
  logic [CHAR_W-1:0] char_q [DIGITS];
  logic [CHAR_W-1:0] fmt    [DIGITS];
  logic              done_q;
  logic              ovf_out_q;
  logic              seen_nz;
  logic [3:0]        nib;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.iStart) state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_q == CNT_W'(1)) state_d = ST_FORMAT;
      ST_FORMAT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Walk from the top digit down; a digit is blanked only while every digit
  // above it (and itself) is zero. Digit 0 always counts as significant.
  always_comb begin
    seen_nz = 1'b0;
    nib     = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      fmt[d] = '0;
    end
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = bcd_q[4*d +: 4];
      if (nib != 4'd0 || d == 0) begin
        seen_nz = 1'b1;
      end
      if (ovf_q) begin
        fmt[d] = CH_MINUS;
      end else if (blank_q && !seen_nz) begin
        fmt[d] = CH_BLANK;
      end else begin
        fmt[d] = CHAR_W'(nib);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      blank_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
        char_q[d] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.iStart) begin
            bin_q   <= bus.iValue;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            blank_q <= bus.iBlank;
            ovf_q   <= (64'(bus.iValue) > MAX_VAL);
          end
        end
        ST_SHIFT: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
          bin_q <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_FORMAT: begin
          for (int d = 0; d < DIGITS; d++) begin
            char_q[d] <= fmt[d];
          end
          ovf_out_q <= ovf_q;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.oBusy     = (state_q != ST_IDLE);
  assign bus.oDone     = done_q;
  assign bus.oOverflow = ovf_out_q;
  assign bus.oChar0    = char_q[0];
  assign bus.oChar1    = char_q[1];
  assign bus.oChar2    = char_q[2];
  assign bus.oChar3    = char_q[3];
  assign bus.oChar4    = char_q[4];
  assign bus.oChar5    = char_q[5];
  assign bus.oChar6    = char_q[6];
  assign bus.oChar7    = char_q[7];

endmodule
